// File: rtl/fod_dtc_cal.sv
// fod_dtc_cal: background LMS calibration of the DTC gain word from the sampler phase-bin error.
// Latency PHE->KDTC 2 CLK edges; no backpressure, one PHE sample is consumed every CLK.
module fod_dtc_cal #(
  parameter int WK         = 16,
  parameter int KINIT      = 512,
  parameter int MU         = 2,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_CNT   = 256,
  parameter int RES_DLY    = 2
) (
  input  logic       CLK,
  input  logic       NARST,
  input  logic       CAL_EN,
  input  logic [2:0] PHE,
  input  logic       PHR_SGN,
  output logic [9:0] KDTC,
  output logic [2:0] PHE_ERR,
  output logic       CAL_LOCK,
  output logic [1:0] CAL_ST
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [WK-1:0] KACC_RST = WK'(KINIT) << (WK - 10);
  localparam logic [WK:0]   STEP     = (WK+1)'(2 ** MU);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t          state_q, state_nxt;
  logic [2:0]      phe_d, phe_ref, phe_ref_nxt, err;
  logic [RES_DLY-1:0] phr_sr;
  logic            phr_d;
  logic [WK-1:0]   kacc, kacc_nxt;
  logic [WK:0]     kacc_up;
  logic [SW-1:0]   settle_cnt, settle_cnt_nxt;
  logic [LW-1:0]   lock_cnt, lock_cnt_nxt;
  logic            err_small, err_big, upd_inc;

  assign phr_d     = phr_sr[RES_DLY-1];
  // Native 3-bit subtraction gives the mod-8 wrap; read as two's complement.
  assign err       = phe_d - phe_ref;
  assign err_small = (err == 3'd0) || (err == 3'd1) || (err == 3'd7);
  assign err_big   = (err == 3'd3) || (err == 3'd4) || (err == 3'd5);
  assign upd_inc   = (~err[2]) == phr_d;
  assign kacc_up   = {1'b0, kacc} + STEP;

  always_comb begin
    state_nxt      = state_q;
    phe_ref_nxt    = phe_ref;
    kacc_nxt       = kacc;
    settle_cnt_nxt = settle_cnt;
    lock_cnt_nxt   = lock_cnt;

    if (CAL_EN && (state_q == ST_TRACK || state_q == ST_LOCKED) && err != 3'd0) begin
      if (upd_inc)
        kacc_nxt = kacc_up[WK] ? '1 : kacc_up[WK-1:0];
      else
        kacc_nxt = ({1'b0, kacc} < STEP) ? '0 : kacc - STEP[WK-1:0];
    end

    if (!CAL_EN) begin
      state_nxt      = ST_IDLE;
      settle_cnt_nxt = '0;
      lock_cnt_nxt   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            phe_ref_nxt  = phe_d;
            state_nxt    = ST_TRACK;
            lock_cnt_nxt = '0;
          end else begin
            settle_cnt_nxt = settle_cnt + SW'(1);
          end
        end
        ST_TRACK: begin
          if (!err_small) begin
            lock_cnt_nxt = '0;
          end else if (lock_cnt == LW'(LOCK_CNT - 1)) begin
            state_nxt    = ST_LOCKED;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + LW'(1);
          end
        end
        ST_LOCKED: begin
          if (err_big) begin
            state_nxt    = ST_TRACK;
            lock_cnt_nxt = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      state_q    <= ST_IDLE;
      phe_d      <= '0;
      phe_ref    <= '0;
      phr_sr     <= '0;
      kacc       <= KACC_RST;
      settle_cnt <= '0;
      lock_cnt   <= '0;
      PHE_ERR    <= '0;
    end else begin
      state_q    <= state_nxt;
      phe_d      <= PHE;
      phe_ref    <= phe_ref_nxt;
      kacc       <= kacc_nxt;
      settle_cnt <= settle_cnt_nxt;
      lock_cnt   <= lock_cnt_nxt;
      PHE_ERR    <= (state_q == ST_IDLE) ? 3'd0 : err;
      phr_sr[0]  <= PHR_SGN;
      for (int i = 1; i < RES_DLY; i++) phr_sr[i] <= phr_sr[i-1];
    end
  end

  assign KDTC     = kacc[WK-1:WK-10];
  assign CAL_LOCK = (state_q == ST_LOCKED);
  assign CAL_ST   = state_q;

endmodule

// File: doc/fod_dtc_cal.md
Name: fod_dtc_cal

Overview:
Background DTC-gain calibration loop for the fractional output divider. It runs on the FOD output clock (FDTC domain). It consumes the 3-bit phase-bin error PHE decoded from the multiphase sampler array, and correlates it with the sign of the fractional phase residue issued by the FOD controller. The result is an LMS-adapted 10-bit DTC gain word (KDTC), which the controller uses to scale DTC_DCW. A lock flag reports when the residual phase error stays within ±1 bin.

Parameters:
WK, 16, accumulator width; KDTC = KACC[WK-1:WK-10]
KINIT, 512, reset/initial KDTC value; KACC resets to KINIT << (WK-10)
MU, 2, LMS step exponent; step = 2**MU LSBs of KACC
SETTLE_CYC, 64, cycles spent in SETTLE before the reference bin is captured
LOCK_CNT, 256, consecutive |e|<=1 samples required to declare lock
RES_DLY, 2, pipeline delay (cycles, >=1) applied to PHR_SGN to align it with PHE

Ports:
CLK  input  1  FOD output clock (FDTC); all logic on rising edge
NARST  input  1  asynchronous active-low reset
CAL_EN  input  1  calibration enable, level
PHE  input  3  phase bin 0..7 from sampler decoder, new value every CLK
PHR_SGN  input  1  sign of DTC phase residue for the current edge (1 = positive)
KDTC  output  10  DTC gain word to FOD controller
PHE_ERR  output  3  signed wrapped error e (two's complement, registered)
CAL_LOCK  output  1  lock flag
CAL_ST  output  2  state: 0 IDLE, 1 SETTLE, 2 TRACK, 3 LOCKED

Behaviour:
- Reset: NARST is asynchronous and active-low; one clock CLK. On reset: KACC = KINIT<<(WK-10), KDTC = KINIT, PHE_ERR = 0, CAL_LOCK = 0, CAL_ST = IDLE, PHE_REF = 0, all counters 0, PHR_SGN delay line 0.
- Stage 1: PHE registered (PHE_d). PHR_SGN passes through an RES_DLY-deep shift register (PHR_d).
- Error: e = (PHE_d - PHE_REF) mod 8, read as signed 3-bit (0..3 → 0..+3; 4..7 → -4..-1). PHE_ERR registers e every cycle in all states except IDLE, where it holds 0.
- Update:
  - Applies in TRACK and LOCKED only, on the edge after PHE_d is captured. Latency from PHE input to KDTC change is 2 edges.
  - e = 0: no change.
  - sign(e) XNOR PHR_d true (e>0 with PHR_d=1, or e<0 with PHR_d=0): KACC += 2**MU.
  - Otherwise: KACC -= 2**MU.
  - Saturate at 0 and 2**WK-1; never wrap.
- FSM:
  - IDLE: when CAL_EN=1, go to SETTLE; settle counter cleared.
  - SETTLE: count SETTLE_CYC cycles. On the last cycle, PHE_REF <= PHE_d, then go to TRACK. No KACC update.
  - TRACK: lock counter increments when |e| <= 1 and clears otherwise. On the edge processing the LOCK_CNT-th consecutive qualifying sample, go to LOCKED with CAL_LOCK=1.
  - LOCKED: updates continue. If |e| >= 3 (e in {+3,-3,-4}), return to TRACK next edge, CAL_LOCK=0, lock counter cleared.
  - CAL_EN=0 in any state: next edge go to IDLE, CAL_LOCK=0, counters cleared. KACC/KDTC hold their value (not reinitialised). PHE_REF is recaptured on the next SETTLE.
- Simultaneous events: CAL_EN deassertion overrides lock/unlock transitions. A saturating update and a lock transition on the same edge both take effect.
- NARST asserted mid-operation returns all state to reset values immediately, regardless of CLK.

Test Plan:
1. Reset, defaults → KDTC=512, CAL_ST=0, CAL_LOCK=0, PHE_ERR=0. Hold for 10 cycles with CAL_EN=0 and random PHE → no change.
2. CAL_EN=1, PHE=3 constant → CAL_ST=1 for 64 cycles, then 2, PHE_REF=3. Then PHE=5, PHR_SGN=1 → PHE_ERR=+2, KACC +4/cycle, KDTC increments by 1 every 16 cycles. With PHR_SGN=0 → KDTC decrements at the same rate.
3. Wrap: PHE_REF=7, PHE=0 → PHE_ERR=+1. PHE_REF=0, PHE=4 → PHE_ERR=-4 (3'b100).
4. Saturation: KINIT=1023, force e=+2/PHR_SGN=1 for 100 cycles → KACC=65535, KDTC=1023, no wrap. Mirror case (KINIT=0, decrement) → KACC=0.
5. Lock: after SETTLE, PHE=PHE_REF for 256 cycles → CAL_LOCK=1 and CAL_ST=3 on exactly the 256th sample. Then one sample with e=+3 → CAL_LOCK=0, CAL_ST=2. A single e=+2 in LOCKED → stays locked. A single e=+2 at count 200 in TRACK → count restarts.
6. Mid-operation: in LOCKED, drop CAL_EN → IDLE next edge, KDTC held. Re-enable → SETTLE again. Assert NARST asynchronously between edges → KDTC=512 and CAL_LOCK=0 immediately.
